button_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 21 ++
 rtl/button_channel.sv | 131 +++++++++++++
 rtl/button_conditioner.sv | 37 +++
 tb/tb_button_conditioner.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding, default
// timing constants and the counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned DEBOUNCE_CYCLES = 500000;
  localparam int unsigned LONG_CYCLES     = 50000000;
  localparam int unsigned REPEAT_CYCLES   = 10000000;

  // Bits needed to count 0..max_val-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, debounce/hold counters and the press FSM.
// Every output is a register.
module button_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = btn_pkg::LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = btn_pkg::REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);
  import btn_pkg::*;

  localparam int unsigned DB_W     = cnt_w(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HOLD_W   = cnt_w(HOLD_MAX);
  localparam bit          REPEAT_EN = (REPEAT_CYCLES > 0);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_EN ? REPEAT_CYCLES - 1 : 0);

  logic [1:0]        r_sync;
  btn_state_e        r_state;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_long_done;

  logic              w_pressed;
  logic              w_enter_held;
  logic              w_hold_step;
  logic              w_hold_run;
  logic              w_hold_hit;
  logic [HOLD_W-1:0] w_hold_last;

  // Synchroniser idles at 1 so a reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], i_btn_n_raw};
  end

  assign w_pressed    = ~r_sync[1];
  assign w_enter_held = (r_state == PRESS_WAIT) && w_pressed && (r_db_cnt == DB_LAST);
  // Hold time accrues while pressed in HELD, including the cycle a release glitch ends.
  assign w_hold_step  = w_pressed && ((r_state == HELD) || (r_state == RELEASE_WAIT));
  assign w_hold_run   = !r_long_done || REPEAT_EN;
  assign w_hold_last  = r_long_done ? REP_LAST : LONG_LAST;
  assign w_hold_hit   = w_hold_run && (r_hold_cnt == w_hold_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_db_cnt  <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pressed) begin
            r_state  <= PRESS_WAIT;
            r_db_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_pressed) begin
            r_state <= IDLE;
          end else if (r_db_cnt == DB_LAST) begin
            r_state <= HELD;
            o_press <= 1'b1;
            o_level <= 1'b1;
          end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
          end
        end
        HELD: begin
          if (!w_pressed) begin
            r_state  <= RELEASE_WAIT;
            r_db_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (w_pressed) begin
            r_state <= HELD;
          end else if (r_db_cnt == DB_LAST) begin
            r_state   <= IDLE;
            o_release <= 1'b1;
            o_level   <= 1'b0;
          end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Hold counter: long strobe once, then periodic repeats; parks when repeat is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt  <= '0;
      r_long_done <= 1'b0;
      o_long      <= 1'b0;
      o_repeat    <= 1'b0;
    end else begin
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
      if (w_enter_held) begin
        r_hold_cnt  <= '0;
        r_long_done <= 1'b0;
      end else if (w_hold_step) begin
        if (w_hold_hit) begin
          r_hold_cnt  <= '0;
          r_long_done <= 1'b1;
          o_long      <= !r_long_done;
          o_repeat    <= r_long_done;
        end else if (w_hold_run) begin
          r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN active-low buttons into debounced levels plus press,
// release, long-press and auto-repeat strobes.
module button_conditioner #(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = btn_pkg::LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = btn_pkg::REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat
);
  import btn_pkg::*;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk         (clk),
      .rst_n       (reset),
      .i_btn_n_raw (btn_n_raw[g]),
      .o_level     (btn_level[g]),
      .o_press     (btn_press[g]),
      .o_release   (btn_release[g]),
      .o_long      (btn_long[g]),
      .o_repeat    (btn_repeat[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing parameters.
`timescale 1ns/1ps
module tb_button_conditioner;

  localparam int unsigned NB = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_n_raw = '1;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;

  button_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .btn_n_raw(btn_n_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  // cyc equals the index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  int press_cnt[NB], rel_cnt[NB], long_cnt[NB], rep_cnt[NB], lvl_cnt[NB];
  int press_at[NB], rel_at[NB], long_at[NB];
  int rep_at[NB][4];
  int press_vec_cycles;
  logic [NB-1:0] first_press_vec;

  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (btn_press[b])   begin press_cnt[b]++; press_at[b] = cyc; end
      if (btn_release[b]) begin rel_cnt[b]++;   rel_at[b]   = cyc; end
      if (btn_long[b])    begin long_cnt[b]++;  long_at[b]  = cyc; end
      if (btn_repeat[b]) begin
        if (rep_cnt[b] < 4) rep_at[b][rep_cnt[b]] = cyc;
        rep_cnt[b]++;
      end
      if (btn_level[b]) lvl_cnt[b]++;
    end
    if (btn_press != '0) begin
      if (press_vec_cycles == 0) first_press_vec = btn_press;
      press_vec_cycles++;
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    for (int b = 0; b < NB; b++) begin
      press_cnt[b] = 0; rel_cnt[b] = 0; long_cnt[b] = 0; rep_cnt[b] = 0; lvl_cnt[b] = 0;
      press_at[b] = -1; rel_at[b] = -1; long_at[b] = -1;
      for (int j = 0; j < 4; j++) rep_at[b][j] = -1;
    end
    press_vec_cycles = 0;
    first_press_vec  = '0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int all_outs();
    return int'({btn_level, btn_press, btn_release, btn_long, btn_repeat});
  endfunction

  int k, kr, r;

  initial begin
    clear_log();
    #1 reset = 1'b0;
    wait_neg(3);
    check_eq("reset_outputs", all_outs(), 0);
    reset = 1'b1;
    wait_neg(5);

    // Clean press on button 0, 10 cycles low.
    clear_log();
    btn_n_raw[0] = 1'b0; k = cyc + 1;
    wait_neg(10);
    btn_n_raw[0] = 1'b1; kr = cyc + 1;
    wait_neg(12);
    check_eq("clean_press_cnt", press_cnt[0], 1);
    check_eq("clean_press_at", press_at[0], k + 6);
    check_eq("clean_rel_cnt", rel_cnt[0], 1);
    check_eq("clean_rel_at", rel_at[0], kr + 6);
    check_eq("clean_level_span", lvl_cnt[0], 10);
    check_eq("clean_no_long", long_cnt[0], 0);

    // Bounce: 1 low / 2 high, shorter than the debounce window.
    clear_log();
    for (int i = 0; i < 7; i++) begin
      btn_n_raw[0] = 1'b0; wait_neg(1);
      btn_n_raw[0] = 1'b1; wait_neg(2);
    end
    wait_neg(10);
    check_eq("bounce_press", press_cnt[0], 0);
    check_eq("bounce_release", rel_cnt[0], 0);
    check_eq("bounce_level", lvl_cnt[0], 0);

    // Long hold on button 1 for 60 cycles.
    clear_log();
    btn_n_raw[1] = 1'b0; k = cyc + 1;
    wait_neg(60);
    btn_n_raw[1] = 1'b1; kr = cyc + 1;
    wait_neg(12);
    check_eq("long_press_cnt", press_cnt[1], 1);
    check_eq("long_press_at", press_at[1], k + 6);
    check_eq("long_cnt", long_cnt[1], 1);
    check_eq("long_delay", long_at[1] - press_at[1], 20);
    check_eq("rep1_delay", rep_at[1][0] - long_at[1], 8);
    check_eq("rep2_delay", rep_at[1][1] - long_at[1], 16);
    check_eq("rep3_delay", rep_at[1][2] - long_at[1], 24);
    check_eq("rep_cnt", rep_cnt[1], 4);
    check_eq("long_rel_cnt", rel_cnt[1], 1);
    check_eq("long_rel_at", rel_at[1], kr + 6);

    // Release glitch on button 2: 2-cycle high pulse while held.
    clear_log();
    btn_n_raw[2] = 1'b0; k = cyc + 1;
    wait_neg(10);
    btn_n_raw[2] = 1'b1;
    wait_neg(2);
    btn_n_raw[2] = 1'b0;
    wait_neg(30);
    btn_n_raw[2] = 1'b1; kr = cyc + 1;
    wait_neg(12);
    check_eq("glitch_press_cnt", press_cnt[2], 1);
    check_eq("glitch_long_delay", long_at[2] - press_at[2], 22);
    check_eq("glitch_rep_cnt", rep_cnt[2], 1);
    check_eq("glitch_rel_cnt", rel_cnt[2], 1);
    check_eq("glitch_rel_at", rel_at[2], kr + 6);
    check_eq("glitch_level_span", lvl_cnt[2], kr - k);

    // Buttons 0 and 2 pressed on the same edge.
    clear_log();
    btn_n_raw = 3'b010; k = cyc + 1;
    wait_neg(10);
    btn_n_raw = 3'b111;
    wait_neg(12);
    check_eq("simul_press_vec", int'(first_press_vec), 5);
    check_eq("simul_press_cycles", press_vec_cycles, 1);
    check_eq("simul_press_at", press_at[2], k + 6);
    check_eq("simul_rel0", rel_cnt[0], 1);
    check_eq("simul_rel2", rel_cnt[2], 1);

    // Reset pulsed while button 0 is held.
    clear_log();
    btn_n_raw[0] = 1'b0; k = cyc + 1;
    wait_neg(10);
    check_eq("pre_reset_level", int'(btn_level[0]), 1);
    reset = 1'b0;
    #1;
    check_eq("reset_async_clear", all_outs(), 0);
    clear_log();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("in_reset_outputs", all_outs(), 0);
    end
    reset = 1'b1; r = cyc + 1;
    wait_neg(12);
    check_eq("post_reset_press_cnt", press_cnt[0], 1);
    check_eq("post_reset_press_at", press_at[0], r + 6);
    check_eq("post_reset_no_release", rel_cnt[0], 0);
    btn_n_raw[0] = 1'b1;
    wait_neg(12);
    check_eq("post_reset_release", rel_cnt[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
